// File: rtl/cpu_mem_responder.sv
// Serves the CPU icache and dcache ports from one single-ported backing memory.
// The data access always goes first; stall is held while any captured access is outstanding.
module cpu_mem_responder #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dcache_addr,
    input  logic [3:0]        dcache_we,
    input  logic              dcache_re,
    input  logic [DATA_W-1:0] dcache_din,
    output logic [DATA_W-1:0] dcache_dout,
    input  logic [31:0]       icache_addr,
    input  logic [3:0]        icache_we,
    input  logic              icache_re,
    input  logic [DATA_W-1:0] icache_din,
    output logic [DATA_W-1:0] instruction,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] i_addr_q;
    logic [3:0]        i_we_q;
    logic [DATA_W-1:0] i_din_q;
    logic              i_pend_q;

    logic d_pend_c;
    logic i_pend_c;
    logic d_wr_c;
    logic i_wr_c;
    logic d_done_c;
    logic unused_addr_bits;

    assign d_pend_c = dcache_re | (|dcache_we);
    assign i_pend_c = icache_re | (|icache_we);
    assign d_wr_c   = |dcache_we;
    assign i_wr_c   = |icache_we;
    assign unused_addr_bits = ^{dcache_addr[1:0], icache_addr[1:0]};

    // Data side finished: posted write accepted or read response returned.
    assign d_done_c = ((state == D_REQ) && mem_req_ready && !mem_req_rnw) ||
                      ((state == D_WAIT) && mem_resp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stall         <= 1'b0;
            dcache_dout   <= '0;
            instruction   <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rnw   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            i_addr_q      <= '0;
            i_we_q        <= '0;
            i_din_q       <= '0;
            i_pend_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i_pend_q <= i_pend_c;
                    i_addr_q <= icache_addr[ADDR_W+1:2];
                    i_we_q   <= icache_we;
                    i_din_q  <= icache_din;
                    if (d_pend_c) begin
                        state         <= D_REQ;
                        stall         <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_rnw   <= !d_wr_c;
                        mem_req_addr  <= dcache_addr[ADDR_W+1:2];
                        mem_req_wdata <= d_wr_c ? dcache_din : '0;
                        mem_req_wmask <= dcache_we;
                    end else if (i_pend_c) begin
                        state         <= I_REQ;
                        stall         <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_rnw   <= !i_wr_c;
                        mem_req_addr  <= icache_addr[ADDR_W+1:2];
                        mem_req_wdata <= i_wr_c ? icache_din : '0;
                        mem_req_wmask <= icache_we;
                    end
                end
                D_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_rnw) begin
                            state <= D_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (mem_resp_valid) begin
                        dcache_dout <= mem_resp_data;
                    end
                end
                I_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_rnw) begin
                            state <= I_WAIT;
                        end else begin
                            state <= IDLE;
                            stall <= 1'b0;
                        end
                    end
                end
                I_WAIT: begin
                    if (mem_resp_valid) begin
                        instruction <= mem_resp_data;
                        state       <= IDLE;
                        stall       <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    stall         <= 1'b0;
                    mem_req_valid <= 1'b0;
                end
            endcase

            // Hand off to the latched instruction access, or return to idle.
            if (d_done_c) begin
                if (i_pend_q) begin
                    state         <= I_REQ;
                    mem_req_valid <= 1'b1;
                    mem_req_rnw   <= !(|i_we_q);
                    mem_req_addr  <= i_addr_q;
                    mem_req_wdata <= (|i_we_q) ? i_din_q : '0;
                    mem_req_wmask <= i_we_q;
                end else begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: vector table plus reset, backpressure and idle sequences.
module tb_cpu_mem_responder;

    localparam int unsigned ADDR_W = 30;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wmask;
    } req_t;

    typedef struct {
        logic        d_re;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_din;
        logic        i_re;
        logic [3:0]  i_we;
        logic [31:0] i_addr;
        logic [31:0] i_din;
        logic [31:0] resp0;
        logic [31:0] resp1;
        int          nreq;
        req_t        req0;
        req_t        req1;
        int          stall_cyc;
        logic [31:0] dout;
        logic [31:0] instr;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [31:0]       dcache_addr;
    logic [3:0]        dcache_we;
    logic              dcache_re;
    logic [31:0]       dcache_din;
    logic [31:0]       dcache_dout;
    logic [31:0]       icache_addr;
    logic [3:0]        icache_we;
    logic              icache_re;
    logic [31:0]       icache_din;
    logic [31:0]       instruction;
    logic              stall;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rnw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic [3:0]        mem_req_wmask;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    int checks = 0;
    int errors = 0;

    req_t        log_q[$];
    logic [31:0] resp_q[$];
    int          hs_total = 0;
    int          hold_cnt = 0;
    bit          auto_resp = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    bit          inject = 1'b0;
    logic [31:0] inject_data = '0;

    vec_t vecs[8];

    cpu_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_re(dcache_re),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout),
        .icache_addr(icache_addr), .icache_we(icache_we), .icache_re(icache_re),
        .icache_din(icache_din), .instruction(instruction),
        .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: log handshakes, queue a response for each accepted read.
    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            log_q.push_back(req_t'({mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask}));
            hs_total = hs_total + 1;
            if (mem_req_rnw && auto_resp && resp_q.size() > 0) begin
                pend_data = resp_q.pop_front();
                pend = 1'b1;
            end
        end
    end

    // Response one cycle after acceptance; ready withheld while hold_cnt runs down.
    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (pend) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend_data;
            pend = 1'b0;
        end else if (inject) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = inject_data;
            inject = 1'b0;
        end
        if (hold_cnt > 0 && mem_req_valid) begin
            mem_req_ready = 1'b0;
            hold_cnt = hold_cnt - 1;
        end else begin
            mem_req_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mkreq(input logic rnw, input logic [ADDR_W-1:0] a,
                                   input logic [31:0] wd, input logic [3:0] wm);
        mkreq = '{rnw: rnw, addr: a, wdata: wd, wmask: wm};
    endfunction

    task automatic clear_cpu();
        dcache_re = 1'b0; dcache_we = '0; dcache_addr = '0; dcache_din = '0;
        icache_re = 1'b0; icache_we = '0; icache_addr = '0; icache_din = '0;
    endtask

    // Returns the number of sampled cycles with stall high, bounded.
    task automatic count_stall(output int cyc);
        int n;
        cyc = 0;
        n = 0;
        while (stall && n < 100) begin
            cyc = cyc + 1;
            @(negedge clk);
            n = n + 1;
        end
        chk("stall_timeout", 128'(stall), 128'(0));
    endtask

    task automatic apply(input int idx, input vec_t v);
        int cyc;
        @(negedge clk);
        log_q.delete();
        resp_q.delete();
        resp_q.push_back(v.resp0);
        resp_q.push_back(v.resp1);
        dcache_re = v.d_re; dcache_we = v.d_we; dcache_addr = v.d_addr; dcache_din = v.d_din;
        icache_re = v.i_re; icache_we = v.i_we; icache_addr = v.i_addr; icache_din = v.i_din;
        @(negedge clk);
        clear_cpu();
        count_stall(cyc);
        chk($sformatf("v%0d_stall_cycles", idx), 128'(cyc), 128'(v.stall_cyc));
        chk($sformatf("v%0d_nreq", idx), 128'(log_q.size()), 128'(v.nreq));
        if (log_q.size() > 0 && v.nreq > 0) chk($sformatf("v%0d_req0", idx), 128'(log_q[0]), 128'(v.req0));
        if (log_q.size() > 1 && v.nreq > 1) chk($sformatf("v%0d_req1", idx), 128'(log_q[1]), 128'(v.req1));
        chk($sformatf("v%0d_dcache_dout", idx), 128'(dcache_dout), 128'(v.dout));
        chk($sformatf("v%0d_instruction", idx), 128'(instruction), 128'(v.instr));
    endtask

    initial begin
        int cyc;
        int hs_before;
        req_t z;
        z = '0;

        vecs[0] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4000_0008, 32'h0,
                    32'h2402_0005, 32'h0, 1,
                    mkreq(1'b1, 30'h1000_0002, 32'h0, 4'h0), z,
                    2, 32'h0, 32'h2402_0005};
        vecs[1] = '{1'b0, 4'b0011, 32'h1000_0020, 32'h0000_ABCD, 1'b1, 4'h0, 32'h0000_0004, 32'h0,
                    32'hAAAA_0001, 32'h0, 2,
                    mkreq(1'b0, 30'h0400_0008, 32'h0000_ABCD, 4'b0011),
                    mkreq(1'b1, 30'h1, 32'h0, 4'h0),
                    3, 32'h0, 32'hAAAA_0001};
        vecs[2] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 4'h0, 32'h0000_0010, 32'h0,
                    32'h1111_2222, 32'h3333_4444, 2,
                    mkreq(1'b1, 30'h40, 32'h0, 4'h0),
                    mkreq(1'b1, 30'h4, 32'h0, 4'h0),
                    4, 32'h1111_2222, 32'h3333_4444};
        vecs[3] = '{1'b1, 4'b1111, 32'h0000_0008, 32'h1234_5678, 1'b0, 4'h0, 32'h0, 32'h0,
                    32'hBAD0_BAD0, 32'h0, 1,
                    mkreq(1'b0, 30'h2, 32'h1234_5678, 4'b1111), z,
                    1, 32'h1111_2222, 32'h3333_4444};
        vecs[4] = '{1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
                    32'hCAFE_F00D, 32'h0, 1,
                    mkreq(1'b1, 30'h3FFF_FFFF, 32'h0, 4'h0), z,
                    2, 32'hCAFE_F00D, 32'h3333_4444};
        vecs[5] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b1000, 32'h0000_0020, 32'hFF00_0000,
                    32'hBAD0_BAD0, 32'h0, 1,
                    mkreq(1'b0, 30'h8, 32'hFF00_0000, 4'b1000), z,
                    1, 32'hCAFE_F00D, 32'h3333_4444};
        vecs[6] = '{1'b0, 4'b0100, 32'h0000_0044, 32'h0055_0000, 1'b0, 4'b0001, 32'h0000_004B, 32'h0000_0077,
                    32'h0, 32'h0, 2,
                    mkreq(1'b0, 30'h11, 32'h0055_0000, 4'b0100),
                    mkreq(1'b0, 30'h12, 32'h0000_0077, 4'b0001),
                    2, 32'hCAFE_F00D, 32'h3333_4444};
        vecs[7] = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 0, z, z,
                    0, 32'hCAFE_F00D, 32'h3333_4444};

        rst_n = 1'b0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        clear_cpu();
        #22;
        chk("reset_stall", 128'(stall), 128'(0));
        chk("reset_valid", 128'(mem_req_valid), 128'(0));
        chk("reset_outputs", 128'({dcache_dout, instruction}), 128'(0));
        chk("reset_req_fields", 128'({mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask}), 128'(0));
        rst_n = 1'b1;

        // Reset while a data read waits for its response.
        auto_resp = 1'b0;
        @(negedge clk);
        dcache_re = 1'b1; dcache_addr = 32'h1000_0010;
        @(negedge clk);
        clear_cpu();
        chk("rst_mid_req", 128'({mem_req_valid, mem_req_rnw, mem_req_addr}),
            128'({1'b1, 1'b1, 30'h0400_0004}));
        @(negedge clk);
        chk("rst_mid_wait", 128'({stall, mem_req_valid}), 128'({1'b1, 1'b0}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_async", 128'({stall, mem_req_valid}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        inject_data = 32'hDEAD_BEEF;
        inject = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_late_resp", 128'({stall, dcache_dout}), 128'(0));
        auto_resp = 1'b1;

        for (int i = 0; i < 8; i++) apply(i, vecs[i]);

        // Backpressure: ready withheld for 5 cycles while a write is offered.
        @(negedge clk);
        hs_before = hs_total;
        hold_cnt = 5;
        dcache_we = 4'hF; dcache_addr = 32'h0000_0200; dcache_din = 32'h5A5A_A5A5;
        @(negedge clk);
        clear_cpu();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d", k), 128'({stall, mem_req_valid, mem_req_addr, mem_req_wdata}),
                128'({1'b1, 1'b1, 30'h80, 32'h5A5A_A5A5}));
            @(negedge clk);
        end
        count_stall(cyc);
        chk("bp_handshakes", 128'(hs_total - hs_before), 128'(1));
        chk("bp_last_cycle_stall", 128'(cyc), 128'(1));

        // Idle with a spurious response.
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                inject_data = 32'h0BAD_F00D;
                inject = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("idle%0d", k), 128'({stall, mem_req_valid, dcache_dout, instruction}),
                128'({1'b0, 1'b0, 32'hCAFE_F00D, 32'h3333_4444}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
